iter_shifter: RTL and testbench

ITER_SHIFTER -- requirements
Module: iter_shifter

---
 rtl/iter_shifter.sv | 92 +++++++++
 tb/tb_iter_shifter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/iter_shifter.sv
// Iterative barrel-shifter replacement: shifts, rotates or sign-extends one bit per cycle.
// A start is accepted only from IDLE; done pulses for exactly one cycle, and then result holds its value.
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   num,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  state_t             state, state_next;
  op_t                op_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_shifted;
  logic [SHAMT_W-1:0] count;
  logic               accept;

  assign accept = (state == IDLE) && start;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (count == SHAMT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // SRA never changes the MSB, so work[WIDTH-1] is always the captured sign bit.
  always_comb begin
    work_shifted = work;
    unique case (op_q)
      OP_SLL: work_shifted = {work[WIDTH-2:0], 1'b0};
      OP_SRL: work_shifted = {1'b0, work[WIDTH-1:1]};
      OP_SRA: work_shifted = {work[WIDTH-1], work[WIDTH-1:1]};
      OP_ROR: work_shifted = {work[0], work[WIDTH-1:1]};
      default: work_shifted = work;
    endcase
  end

  // SHIFT is entered only with count >= 1 and left at count == 1, so count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      count <= '0;
      op_q  <= OP_SLL;
    end else if (accept) begin
      work  <= num;
      count <= shamt;
      op_q  <= op_t'(op);
    end else if (state == SHIFT) begin
      work  <= work_shifted;
      count <= count - SHAMT_W'(1);
    end
  end

  assign result = work;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: directed table, multi-cycle corner sequences,
// and a 1000-operation back-to-back random run checked against an arithmetic reference.
module tb_iter_shifter;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   num;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  iter_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .num(num), .shamt(shamt),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [1:0]         op;
    logic [WIDTH-1:0]   num;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   exp;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] ref_model(input logic [1:0] o, input logic [WIDTH-1:0] n,
                                                 input int s);
    logic [2*WIDTH-1:0] d;
    case (o)
      2'b00:   return n << s;
      2'b01:   return n >> s;
      2'b10:   return WIDTH'($signed(n) >>> s);
      default: begin
        d = {n, n} >> s;
        return d[WIDTH-1:0];
      end
    endcase
  endfunction

  // Issue one op from IDLE and wait (bounded) for done; ends in the IDLE cycle after done.
  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] n, input logic [SHAMT_W-1:0] s,
                        output logic [WIDTH-1:0] res, output int lat, output int busy_cyc,
                        output bit timed_out);
    start = 1'b1; op = o; num = n; shamt = s;
    step();
    start = 1'b0; num = '0;
    lat = -1; busy_cyc = 0; timed_out = 1'b1; res = '0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      if (busy) busy_cyc++;
      if (done) begin
        lat = k; res = result; timed_out = 1'b0;
        break;
      end
      step();
    end
    step();
  endtask

  logic [WIDTH-1:0]   res;
  int                 lat, busy_cyc, d0;
  bit                 tout, bad;
  logic [1:0]         cur_op;
  logic [WIDTH-1:0]   cur_num;
  logic [SHAMT_W-1:0] cur_s;

  initial begin
    tbl[0]  = '{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010};
    tbl[1]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    tbl[2]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
    tbl[3]  = '{2'b11, 32'h0000_000F, 5'd4,  32'hF000_0000};
    tbl[4]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[5]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[6]  = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[7]  = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    tbl[8]  = '{2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    tbl[9]  = '{2'b11, 32'h1234_5678, 5'd31, 32'h2468_ACF0};
    tbl[10] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    tbl[11] = '{2'b10, 32'h8000_0000, 5'd1,  32'hC000_0000};
    tbl[12] = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000};

    rst = 1'b1; start = 1'b0; op = '0; num = '0; shamt = '0;
    step(); step();
    check("reset_busy",   WIDTH'(busy), '0);
    check("reset_done",   WIDTH'(done), '0);
    check("reset_result", result, '0);
    rst = 1'b0;
    step();

    // Directed table: result, latency (done after edge T+shamt), busy width, return to IDLE
    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].num, tbl[i].shamt, res, lat, busy_cyc, tout);
      check($sformatf("tbl%0d_timeout", i), WIDTH'(tout), '0);
      check($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      check($sformatf("tbl%0d_latency", i), WIDTH'(lat), WIDTH'(tbl[i].shamt));
      check($sformatf("tbl%0d_busy_cycles", i), WIDTH'(busy_cyc), WIDTH'(tbl[i].shamt) + 1);
      check($sformatf("tbl%0d_idle_after", i), WIDTH'({busy, done}), '0);
    end

    // start pulsed mid-SHIFT with different operands must be ignored
    d0 = done_cnt;
    start = 1'b1; op = 2'b00; num = 32'h1; shamt = 5'd10;
    step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1; op = 2'b01; num = 32'h0000_FFFF; shamt = 5'd1;
    step();
    start = 1'b0;
    lat = -1; res = '0;
    for (int k = 4; k < WIDTH + 8; k++) begin
      if (done) begin lat = k; res = result; break; end
      step();
    end
    check("ignore_start_result",  res, 32'h0000_0400);
    check("ignore_start_latency", WIDTH'(lat), 32'd10);
    repeat (6) step();
    check("ignore_start_one_done", WIDTH'(done_cnt - d0), 32'd1);
    check("ignore_start_idle",     WIDTH'(busy), '0);

    // rst mid-SHIFT aborts without a done pulse
    start = 1'b1; op = 2'b10; num = 32'h8000_0000; shamt = 5'd20;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    check("abort_busy",   WIDTH'(busy), '0);
    check("abort_done",   WIDTH'(done), '0);
    check("abort_result", result, '0);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (25) step();
    check("abort_no_done", WIDTH'(done_cnt - d0), '0);
    run_op(2'b11, 32'h0000_000F, 5'd4, res, lat, busy_cyc, tout);
    check("after_abort_result",  res, 32'hF000_0000);
    check("after_abort_latency", WIDTH'(lat), 32'd4);

    // Back-to-back with start held high; operands for the next op appear in the DONE
    // cycle, so a wrongly accepted start there shows up as a timing/result error.
    cur_op = 2'($urandom_range(0, 3)); cur_num = $urandom; cur_s = SHAMT_W'($urandom_range(0, 31));
    start = 1'b1; op = cur_op; num = cur_num; shamt = cur_s;
    step();
    for (int i = 0; i < 1000; i++) begin
      bad = 1'b0;
      for (int k = 0; k < int'(cur_s); k++) begin
        if (done || !busy) bad = 1'b1;
        step();
      end
      if (!done || !busy) bad = 1'b1;
      check($sformatf("b2b%0d_result", i), result, ref_model(cur_op, cur_num, int'(cur_s)));
      cur_op = 2'($urandom_range(0, 3)); cur_num = $urandom; cur_s = SHAMT_W'($urandom_range(0, 31));
      op = cur_op; num = cur_num; shamt = cur_s;
      if (i == 999) start = 1'b0;
      step();
      if (busy || done) bad = 1'b1;
      check($sformatf("b2b%0d_timing", i), WIDTH'(bad), '0);
      step();
    end
    start = 1'b0;
    repeat (3) step();
    check("final_idle", WIDTH'({busy, done}), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
